// File: rtl/calc_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : calc_cmd_arbiter
// Purpose  : Two-requester command arbiter and sequencer in front of the
//            calculator core. It grants one command at a time, then drives the
//            core's cmd input with a hold/gap waveform and waits for the core's
//            status. It also locks the core to one requester for the length of
//            an expression.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   1  system clock, rising edge
//   reset        in   1  synchronous active-high reset
//   req0/req1    in   1  command request per requester, held until ack
//   cmd0/cmd1    in   4  command per requester, stable while req is high
//   ack0/ack1    out  1  one-cycle grant pulse
//   calc_cmd     out  4  command to the calculator core (1111 = NOP)
//   calc_status  in   2  core status: 00 ready, 01 busy, 10 error, 11 ready
//   lock_owner   out  2  one-hot expression owner, 00 = unlocked
//   busy         out  1  sequencer is not idle
//   err          out  1  one-cycle pulse when the core reports an error
// ============================================================================
module calc_cmd_arbiter #(
    parameter int HOLD_CYCLES    = 10,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] cmd0,
    input  logic [3:0] cmd1,
    output logic       ack0,
    output logic       ack1,
    output logic [3:0] calc_cmd,
    input  logic [1:0] calc_status,
    output logic [1:0] lock_owner,
    output logic       busy,
    output logic       err
);

    localparam logic [3:0] CMD_LAST_LOCKING = 4'hC;  // digits and add/sub/mul
    localparam logic [3:0] CMD_CLEAR        = 4'hD;
    localparam logic [3:0] CMD_EQUALS       = 4'hE;
    localparam logic [3:0] CMD_NOP          = 4'hF;
    localparam logic [1:0] STAT_BUSY        = 2'b01;
    localparam logic [1:0] STAT_ERROR       = 2'b10;

    localparam int PH_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int PW     = $clog2(PH_MAX + 1);
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0] HOLD_LOAD = PW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0] GAP_LOAD  = PW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_GAP        = 2'd2,
        S_WAIT_READY = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_cnt_q, phase_cnt_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          rr_last_q, rr_last_d;     // requester granted most recently
    logic [1:0]    lock_q, lock_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [3:0]    calc_cmd_q, calc_cmd_d;
    logic          busy_q;
    logic          err_q, err_d;

    logic          want0, want1, grant_any, grant_sel, owner_req;
    logic [3:0]    grant_cmd;

    // Arbitration: eligibility comes from the lock value before this edge.
    always_comb begin
        want0     = req0 && ((lock_q == 2'b00) || lock_q[0]);
        want1     = req1 && ((lock_q == 2'b00) || lock_q[1]);
        grant_any = want0 || want1;
        if (want0 && want1) begin
            grant_sel = ~rr_last_q;
        end else begin
            grant_sel = want1;
        end
        grant_cmd = grant_sel ? cmd1 : cmd0;
        owner_req = (lock_q[0] && req0) || (lock_q[1] && req1);
    end

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        idle_cnt_d  = '0;
        cmd_d       = cmd_q;
        rr_last_d   = rr_last_q;
        lock_d      = lock_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        calc_cmd_d  = calc_cmd_q;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                calc_cmd_d = CMD_NOP;
                if (grant_any) begin
                    cmd_d     = grant_cmd;
                    rr_last_d = grant_sel;
                    ack0_d    = ~grant_sel;
                    ack1_d    = grant_sel;
                    if (grant_cmd <= CMD_LAST_LOCKING) begin
                        lock_d = grant_sel ? 2'b10 : 2'b01;
                    end
                    if (grant_cmd == CMD_NOP) begin
                        // Accepted but never forwarded: the gap keeps the
                        // requester's still-high req from being re-sampled.
                        state_d     = S_GAP;
                        phase_cnt_d = GAP_LOAD;
                    end else begin
                        state_d     = S_ISSUE;
                        phase_cnt_d = HOLD_LOAD;
                        calc_cmd_d  = grant_cmd;
                    end
                end else if ((lock_q != 2'b00) && !owner_req) begin
                    if (idle_cnt_q == TMO_LAST) begin
                        // Abandoned expression: push a clear through the core
                        // and let WAIT_READY drop the lock.
                        cmd_d       = CMD_CLEAR;
                        state_d     = S_ISSUE;
                        phase_cnt_d = HOLD_LOAD;
                        calc_cmd_d  = CMD_CLEAR;
                    end else begin
                        idle_cnt_d = idle_cnt_q + TW'(1);
                    end
                end
            end
            S_ISSUE: begin
                if (phase_cnt_q == '0) begin
                    state_d     = S_GAP;
                    phase_cnt_d = GAP_LOAD;
                    calc_cmd_d  = CMD_NOP;
                end else begin
                    phase_cnt_d = phase_cnt_q - PW'(1);
                end
            end
            S_GAP: begin
                calc_cmd_d = CMD_NOP;
                if (phase_cnt_q == '0) begin
                    state_d = S_WAIT_READY;
                end else begin
                    phase_cnt_d = phase_cnt_q - PW'(1);
                end
            end
            S_WAIT_READY: begin
                calc_cmd_d = CMD_NOP;
                if (calc_status != STAT_BUSY) begin
                    state_d = S_IDLE;
                    if (calc_status == STAT_ERROR) begin
                        err_d  = 1'b1;
                        lock_d = 2'b00;
                    end else if ((cmd_q == CMD_CLEAR) || (cmd_q == CMD_EQUALS)) begin
                        lock_d = 2'b00;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_cnt_q <= '0;
            idle_cnt_q  <= '0;
            cmd_q       <= CMD_NOP;
            rr_last_q   <= 1'b1;
            lock_q      <= 2'b00;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            calc_cmd_q  <= CMD_NOP;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            cmd_q       <= cmd_d;
            rr_last_q   <= rr_last_d;
            lock_q      <= lock_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            calc_cmd_q  <= calc_cmd_d;
            busy_q      <= (state_d != S_IDLE);
            err_q       <= err_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign calc_cmd   = calc_cmd_q;
    assign lock_owner = lock_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule
`default_nettype wire
